// File: rtl/word_send_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : word_send_queue_if
//  Description : Word-in / byte-out handshake bundle for word_send_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
interface word_send_queue_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [31:0]         word_in;
    logic                word_valid;
    logic                sender_ready;
    logic [7:0]          sender_data;
    logic                sender_enable;
    logic                full;
    logic                empty;
    logic                busy;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;

    // master is the surrounding system: execution stage plus byte sender
    modport master (
        output word_in, word_valid, sender_ready,
        input  sender_data, sender_enable, full, empty, busy, count, overflow
    );

    modport slave (
        input  word_in, word_valid, sender_ready,
        output sender_data, sender_enable, full, empty, busy, count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/word_send_queue.sv
`default_nettype none
// ============================================================================
//  Module      : word_send_queue
//  Description : Word FIFO that serialises 32-bit words into 4 bytes for the
//                byte-level UART sender.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_send_queue #(
    parameter int DEPTH_LOG2   = 4,
    parameter int AFULL_MARGIN = 4,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  wire logic         CLK,
    input  wire logic         reset_n,
    word_send_queue_if.slave  bus
);

    localparam int                  c_DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH_CNT = (DEPTH_LOG2 + 1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0] c_AFULL_LVL = (DEPTH_LOG2 + 1)'(c_DEPTH - AFULL_MARGIN);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_LOW  = 2'd2,
        ST_WAIT_HIGH = 2'd3
    } state_t;

    state_t                r_state;
    logic [31:0]           r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DEPTH_LOG2:0]   w_count_next;
    logic [31:0]           r_shifter;
    logic [31:0]           w_shifted;
    logic [7:0]            w_cur_byte;
    logic [1:0]            r_byte_idx;
    logic [7:0]            r_sender_data;
    logic                  r_sender_enable;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_busy;
    logic                  r_overflow;
    logic                  w_have_word;
    logic                  w_push;
    logic                  w_pop;

    assign w_have_word = (r_count != '0);
    // Full check uses the registered count: a same-cycle pop cannot make room
    assign w_push      = bus.word_valid && (r_count != c_DEPTH_CNT);
    assign w_pop       = ((r_state == ST_IDLE) && w_have_word) ||
                         ((r_state == ST_WAIT_HIGH) && bus.sender_ready &&
                          (r_byte_idx == 2'd3) && w_have_word);

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_cur_byte = r_shifter[31:24];
            assign w_shifted  = {r_shifter[23:0], 8'h00};
        end else begin : g_lsb_first
            assign w_cur_byte = r_shifter[7:0];
            assign w_shifted  = {8'h00, r_shifter[31:8]};
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (reset_n && w_push) begin
            r_mem[r_wr_ptr] <= bus.word_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (bus.word_valid && !w_push) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next >= c_AFULL_LVL);
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_shifter       <= '0;
            r_byte_idx      <= 2'd0;
            r_sender_data   <= 8'h00;
            r_sender_enable <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_sender_enable <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_have_word) begin
                        r_shifter  <= r_mem[r_rd_ptr];
                        r_byte_idx <= 2'd0;
                        r_state    <= ST_SEND;
                        r_busy     <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (bus.sender_ready) begin
                        r_sender_data   <= w_cur_byte;
                        r_sender_enable <= 1'b1;
                        r_shifter       <= w_shifted;
                        r_state         <= ST_WAIT_LOW;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!bus.sender_ready) begin
                        r_state <= ST_WAIT_HIGH;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (bus.sender_ready) begin
                        if (r_byte_idx == 2'd3) begin
                            // Chain straight into the next word with no idle gap
                            if (w_have_word) begin
                                r_shifter  <= r_mem[r_rd_ptr];
                                r_byte_idx <= 2'd0;
                                r_state    <= ST_SEND;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_state    <= ST_SEND;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sender_data   = r_sender_data;
    assign bus.sender_enable = r_sender_enable;
    assign bus.full          = r_full;
    assign bus.empty         = r_empty;
    assign bus.busy          = r_busy;
    assign bus.count         = r_count;
    assign bus.overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_word_send_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_word_send_queue
//  Description : Scoreboard bench for word_send_queue (MSB- and LSB-first).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_word_send_queue;

    logic CLK;
    logic reset_n;
    logic ready;
    logic hold;
    logic sel;

    word_send_queue_if #(.DEPTH_LOG2(4)) bus_m ();
    word_send_queue_if #(.DEPTH_LOG2(4)) bus_l ();

    word_send_queue #(.DEPTH_LOG2(4), .AFULL_MARGIN(4), .MSB_FIRST(1'b1)) dut_m (
        .CLK(CLK), .reset_n(reset_n), .bus(bus_m)
    );
    word_send_queue #(.DEPTH_LOG2(4), .AFULL_MARGIN(4), .MSB_FIRST(1'b0)) dut_l (
        .CLK(CLK), .reset_n(reset_n), .bus(bus_l)
    );

    assign bus_m.sender_ready = ready;
    assign bus_l.sender_ready = ready;

    logic       sel_en;
    logic [7:0] sel_data;
    logic       sel_busy;
    assign sel_en   = sel ? bus_l.sender_enable : bus_m.sender_enable;
    assign sel_data = sel ? bus_l.sender_data   : bus_m.sender_data;
    assign sel_busy = sel ? bus_l.busy          : bus_m.busy;

    logic [7:0] sb [$];
    int n_tests = 0;
    int n_fail  = 0;
    int n_en    = 0;
    int n_rise  = 0;
    int n_resets = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Byte sender: ready drops one cycle after enable and stays low 10 cycles
    initial begin : sender_model
        logic [7:0] got;
        logic [7:0] exp;
        int         rs;
        forever begin
            @(posedge CLK); #1;
            if (hold) begin
                ready = 1'b0;
            end else if (sel_en) begin
                got = sel_data;
                rs  = n_resets;
                n_en++;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL byte_unexpected: got %02h, required no byte", got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL byte_order: got %02h, required %02h", got, exp);
                    end
                end
                @(posedge CLK); #1;
                ready = 1'b0;
                repeat (10) @(posedge CLK);
                #1;
                if (rs == n_resets) begin
                    n_tests++;
                    if (sel_data !== got) begin
                        n_fail++;
                        $display("FAIL data_stable: got %02h, required %02h", sel_data, got);
                    end
                end
                ready = 1'b1;
                n_rise++;
            end else begin
                ready = 1'b1;
            end
        end
    end

    task automatic write_word(input logic [31:0] w, input bit accept);
        if (sel) begin
            bus_l.word_in = w; bus_l.word_valid = 1'b1;
        end else begin
            bus_m.word_in = w; bus_m.word_valid = 1'b1;
        end
        if (accept) begin
            if (!sel) for (int i = 3; i >= 0; i--) sb.push_back(w[8*i +: 8]);
            else      for (int i = 0; i < 4; i++)  sb.push_back(w[8*i +: 8]);
        end
        @(posedge CLK); #1;
        bus_m.word_valid = 1'b0;
        bus_l.word_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input bit check_gap);
        int cyc;
        bit gap;
        cyc = 0;
        gap = 1'b0;
        while ((sb.size() != 0 || sel_busy) && cyc < 5000) begin
            @(posedge CLK); #1;
            cyc++;
            if (check_gap && sb.size() != 0 && !sel_busy) gap = 1'b1;
        end
        n_tests++;
        if (cyc >= 5000) begin
            n_fail++;
            $display("FAIL drain_%s: timed out with %0d bytes pending, required 0", name, sb.size());
        end
        if (check_gap) begin
            n_tests++;
            if (gap) begin
                n_fail++;
                $display("FAIL no_gap_%s: busy dropped between words, required continuous", name);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_tests++; if (bus_m.count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d, required 0", bus_m.count); end
        n_tests++; if (bus_m.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b, required 1", bus_m.empty); end
        n_tests++; if (bus_m.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b, required 0", bus_m.full); end
        n_tests++; if (bus_m.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", bus_m.busy); end
        n_tests++; if (bus_m.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b, required 0", bus_m.overflow); end
        n_tests++; if (bus_m.sender_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b, required 0", bus_m.sender_enable); end
        n_tests++; if (bus_m.sender_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %02h, required 00", bus_m.sender_data); end
        reset_n = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_single_msb();
        int base;
        sel  = 1'b0;
        base = n_en;
        write_word(32'h11223344, 1'b1);
        n_tests++; if (bus_m.count !== 5'd1) begin n_fail++; $display("FAIL lat_count: got %0d, required 1", bus_m.count); end
        n_tests++; if (bus_m.empty !== 1'b0) begin n_fail++; $display("FAIL lat_empty: got %b, required 0", bus_m.empty); end
        @(posedge CLK); #1;
        n_tests++; if (bus_m.count !== 5'd0) begin n_fail++; $display("FAIL lat_pop: got %0d, required 0", bus_m.count); end
        n_tests++; if (bus_m.busy !== 1'b1) begin n_fail++; $display("FAIL lat_busy: got %b, required 1", bus_m.busy); end
        @(posedge CLK); #1;
        n_tests++; if (bus_m.sender_enable !== 1'b1) begin n_fail++; $display("FAIL lat_enable: got %b, required 1", bus_m.sender_enable); end
        n_tests++; if (bus_m.sender_data !== 8'h11) begin n_fail++; $display("FAIL lat_byte0: got %02h, required 11", bus_m.sender_data); end
        wait_drain("msb", 1'b0);
        n_tests++; if (n_en - base !== 4) begin n_fail++; $display("FAIL msb_pulses: got %0d, required 4", n_en - base); end
        n_tests++; if (bus_m.empty !== 1'b1) begin n_fail++; $display("FAIL msb_empty: got %b, required 1", bus_m.empty); end
        n_tests++; if (bus_m.busy !== 1'b0) begin n_fail++; $display("FAIL msb_busy: got %b, required 0", bus_m.busy); end
    endtask

    task automatic test_lsb();
        int base;
        sel  = 1'b1;
        base = n_en;
        write_word(32'hA1B2C3D4, 1'b1);
        wait_drain("lsb", 1'b0);
        n_tests++; if (n_en - base !== 4) begin n_fail++; $display("FAIL lsb_pulses: got %0d, required 4", n_en - base); end
        n_tests++; if (bus_l.busy !== 1'b0) begin n_fail++; $display("FAIL lsb_busy: got %b, required 0", bus_l.busy); end
        sel = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_overflow();
        int exp_cnt;
        hold = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        // First word parks in the shifter so the FIFO itself can fill to 16
        write_word($urandom, 1'b1);
        repeat (3) @(posedge CLK);
        #1;
        n_tests++; if (bus_m.count !== 5'd0) begin n_fail++; $display("FAIL ovf_parked: got %0d, required 0", bus_m.count); end
        for (int k = 1; k <= 17; k++) begin
            write_word($urandom, k <= 16);
            exp_cnt = (k > 16) ? 16 : k;
            n_tests++; if (bus_m.count !== 5'(exp_cnt)) begin n_fail++; $display("FAIL ovf_count_%0d: got %0d, required %0d", k, bus_m.count, exp_cnt); end
            n_tests++; if (bus_m.full !== (exp_cnt >= 12)) begin n_fail++; $display("FAIL ovf_full_%0d: got %b, required %b", k, bus_m.full, exp_cnt >= 12); end
            n_tests++; if (bus_m.overflow !== (k == 17)) begin n_fail++; $display("FAIL ovf_flag_%0d: got %b, required %b", k, bus_m.overflow, k == 17); end
        end
        hold = 1'b0;
        wait_drain("overflow", 1'b1);
        n_tests++; if (bus_m.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b, required 1", bus_m.overflow); end
        reset_n = 1'b0;
        n_resets++;
        @(posedge CLK); #1;
        reset_n = 1'b1;
        sb.delete();
        n_tests++; if (bus_m.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b, required 0", bus_m.overflow); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 40; i++) begin
            write_word($urandom, 1'b1);
            repeat (35) @(posedge CLK);
            #1;
        end
        wait_drain("wrap", 1'b0);
        n_tests++; if (bus_m.count !== 5'd0) begin n_fail++; $display("FAIL wrap_count: got %0d, required 0", bus_m.count); end
        n_tests++; if (bus_m.overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_overflow: got %b, required 0", bus_m.overflow); end
    endtask

    task automatic test_same_cycle();
        int base;
        int cyc;
        hold = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        write_word($urandom, 1'b1);
        repeat (3) @(posedge CLK);
        #1;
        for (int k = 0; k < 5; k++) write_word($urandom, 1'b1);
        n_tests++; if (bus_m.count !== 5'd5) begin n_fail++; $display("FAIL same_pre: got %0d, required 5", bus_m.count); end
        base = n_rise;
        hold = 1'b0;
        cyc  = 0;
        while (n_rise != base + 4 && cyc < 2000) begin
            @(posedge CLK); #2;
            cyc++;
        end
        n_tests++; if (cyc >= 2000) begin n_fail++; $display("FAIL same_wait: timed out, got %0d rises, required %0d", n_rise - base, 4); end
        // The FSM pops on this edge while the write lands on the same edge
        write_word(32'h5A5A0F0F, 1'b1);
        n_tests++; if (bus_m.count !== 5'd5) begin n_fail++; $display("FAIL same_count: got %0d, required 5", bus_m.count); end
        wait_drain("same", 1'b0);
    endtask

    task automatic test_reset_mid();
        int base;
        int cyc;
        base = n_en;
        write_word(32'hDEADBEEF, 1'b1);
        for (int k = 0; k < 3; k++) write_word($urandom, 1'b1);
        n_tests++; if (bus_m.count !== 5'd3) begin n_fail++; $display("FAIL mid_queued: got %0d, required 3", bus_m.count); end
        cyc = 0;
        while (n_en != base + 2 && cyc < 500) begin
            @(posedge CLK); #2;
            cyc++;
        end
        n_tests++; if (cyc >= 500) begin n_fail++; $display("FAIL mid_wait: timed out, got %0d bytes, required 2", n_en - base); end
        reset_n = 1'b0;
        n_resets++;
        @(posedge CLK); #1;
        n_tests++; if (bus_m.count !== 5'd0) begin n_fail++; $display("FAIL mid_count: got %0d, required 0", bus_m.count); end
        n_tests++; if (bus_m.sender_enable !== 1'b0) begin n_fail++; $display("FAIL mid_enable: got %b, required 0", bus_m.sender_enable); end
        n_tests++; if (bus_m.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b, required 0", bus_m.busy); end
        n_tests++; if (bus_m.overflow !== 1'b0) begin n_fail++; $display("FAIL mid_overflow: got %b, required 0", bus_m.overflow); end
        reset_n = 1'b1;
        sb.delete();
        base = n_en;
        repeat (150) @(posedge CLK);
        #1;
        n_tests++; if (n_en !== base) begin n_fail++; $display("FAIL mid_silent: got %0d bytes, required 0", n_en - base); end
        n_tests++; if (bus_m.busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got %b, required 0", bus_m.busy); end
    endtask

    initial begin
        reset_n = 1'b0;
        ready   = 1'b1;
        hold    = 1'b0;
        sel     = 1'b0;
        bus_m.word_in = '0; bus_m.word_valid = 1'b0;
        bus_l.word_in = '0; bus_l.word_valid = 1'b0;
        test_reset();
        test_single_msb();
        test_lsb();
        test_overflow();
        test_wrap();
        test_same_cycle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
